// File: rtl/alu_multicycle_if.sv
// Handshake and operand/result bundle for alu_multicycle.
// master = operand producer / result consumer, slave = execute unit.
interface alu_multicycle_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       alu_ctl;
  logic             sign;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;

  modport master (
    output in_valid, alu_ctl, sign, in1, in2, out_ready,
    input  in_ready, out_valid, result, zero
  );

  modport slave (
    input  in_valid, alu_ctl, sign, in1, in2, out_ready,
    output in_ready, out_valid, result, zero
  );
endinterface

// File: rtl/alu_multicycle.sv
// Iterative EX-stage ALU with valid/ready handshake; shifts run one bit per cycle.
// Define ALU_FAST_SHIFT_EN to replace the iterative shifter with a single-cycle barrel shifter.
module alu_multicycle #(
  parameter int unsigned WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  alu_multicycle_if.slave bus
);

  localparam int unsigned SHAMT_W = 5;

  localparam logic [4:0] OP_AND = 5'b00000;
  localparam logic [4:0] OP_OR  = 5'b00001;
  localparam logic [4:0] OP_ADD = 5'b00010;
  localparam logic [4:0] OP_SUB = 5'b00110;
  localparam logic [4:0] OP_SLT = 5'b00111;
  localparam logic [4:0] OP_NOR = 5'b01100;
  localparam logic [4:0] OP_XOR = 5'b01101;
  localparam logic [4:0] OP_SLL = 5'b10000;
  localparam logic [4:0] OP_SRL = 5'b11000;
  localparam logic [4:0] OP_SRA = 5'b11001;

  localparam logic [1:0] IDLE  = 2'd0;
`ifndef ALU_FAST_SHIFT_EN
  localparam logic [1:0] SHIFT = 2'd1;
`endif
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]         state, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   op_result;
  logic [SHAMT_W-1:0] shamt;

  assign shamt = bus.in1[SHAMT_W-1:0];

  // Single-cycle result for everything the iterative path does not handle
  always_comb begin
    op_result = '0;
    case (bus.alu_ctl)
      OP_AND: op_result = bus.in1 & bus.in2;
      OP_OR:  op_result = bus.in1 | bus.in2;
      OP_ADD: op_result = bus.in1 + bus.in2;
      OP_SUB: op_result = bus.in1 - bus.in2;
      OP_SLT: begin
        if (bus.sign) op_result = WIDTH'($signed(bus.in1) < $signed(bus.in2));
        else          op_result = WIDTH'(bus.in1 < bus.in2);
      end
      OP_NOR: op_result = ~(bus.in1 | bus.in2);
      OP_XOR: op_result = bus.in1 ^ bus.in2;
`ifdef ALU_FAST_SHIFT_EN
      OP_SLL: op_result = bus.in2 << shamt;
      OP_SRL: op_result = bus.in2 >> shamt;
      OP_SRA: op_result = WIDTH'($signed(bus.in2) >>> shamt);
`endif
      default: op_result = '0;
    endcase
  end

`ifndef ALU_FAST_SHIFT_EN
  logic               is_shift;
  logic [SHAMT_W-1:0] cnt, cnt_d;
  logic [WIDTH-1:0]   work, work_d, work_step;
  logic [4:0]         ctl_q, ctl_d;

  assign is_shift = (bus.alu_ctl == OP_SLL) || (bus.alu_ctl == OP_SRL) ||
                    (bus.alu_ctl == OP_SRA);

  // One-bit step of the working register in the latched direction
  always_comb begin
    work_step = work;
    case (ctl_q)
      OP_SLL:  work_step = {work[WIDTH-2:0], 1'b0};
      OP_SRL:  work_step = {1'b0, work[WIDTH-1:1]};
      OP_SRA:  work_step = {work[WIDTH-1], work[WIDTH-1:1]};
      default: work_step = work;
    endcase
  end
`endif

  // Next state and datapath
  always_comb begin
    state_d  = state;
    result_d = result_q;
`ifndef ALU_FAST_SHIFT_EN
    cnt_d    = cnt;
    work_d   = work;
    ctl_d    = ctl_q;
`endif
    case (state)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          state_d = DONE;
`ifdef ALU_FAST_SHIFT_EN
          result_d = op_result;
`else
          if (!is_shift) begin
            result_d = op_result;
          end else if (shamt == '0) begin
            result_d = bus.in2;
          end else begin
            state_d = SHIFT;
            ctl_d   = bus.alu_ctl;
            work_d  = bus.in2;
            cnt_d   = shamt;
          end
`endif
        end
      end
`ifndef ALU_FAST_SHIFT_EN
      SHIFT: begin
        work_d = work_step;
        cnt_d  = cnt - SHAMT_W'(1);
        if (cnt == SHAMT_W'(1)) begin
          result_d = work_step;
          state_d  = DONE;
        end
      end
`endif
      DONE: begin
        if (bus.out_ready && out_valid_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Flags require the state to persist across an edge, so they rise one
    // cycle after entering IDLE/DONE and drop on the edge that leaves it.
    in_ready_d  = (state == IDLE) && (state_d == IDLE);
    out_valid_d = (state == DONE) && (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      result_q    <= '0;
      zero_q      <= 1'b1;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state       <= state_d;
      result_q    <= result_d;
      zero_q      <= (result_d == '0);
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifndef ALU_FAST_SHIFT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      work  <= '0;
      ctl_q <= '0;
    end else begin
      cnt   <= cnt_d;
      work  <= work_d;
      ctl_q <= ctl_d;
    end
  end
`endif

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed self-checking bench for alu_multicycle (both shift builds).
module tb_alu_multicycle;

  localparam logic [4:0] OP_AND = 5'b00000;
  localparam logic [4:0] OP_OR  = 5'b00001;
  localparam logic [4:0] OP_ADD = 5'b00010;
  localparam logic [4:0] OP_SUB = 5'b00110;
  localparam logic [4:0] OP_SLT = 5'b00111;
  localparam logic [4:0] OP_NOR = 5'b01100;
  localparam logic [4:0] OP_XOR = 5'b01101;
  localparam logic [4:0] OP_SLL = 5'b10000;
  localparam logic [4:0] OP_SRL = 5'b11000;
  localparam logic [4:0] OP_SRA = 5'b11001;
  localparam logic [4:0] OP_UND = 5'b00011;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_multicycle_if #(.WIDTH(32)) bus();

  alu_multicycle #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Single-cycle op vectors: ctl, sign, in1, in2, expected result
  logic [4:0]  lv_ctl [12] = '{OP_AND, OP_OR, OP_ADD, OP_ADD, OP_SUB, OP_NOR,
                               OP_XOR, OP_SLT, OP_SLT, OP_SLT, OP_SLT, OP_UND};
  logic        lv_sg  [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                               1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [31:0] lv_a   [12] = '{32'h0F0F_F0F0, 32'h0F0F_F0F0, 32'hFFFF_FFFF, 32'h7FFF_FFFF,
                               32'h0000_0005, 32'h0F0F_F0F0, 32'h0F0F_F0F0, 32'h8000_0000,
                               32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 32'hFFFF_FFFF};
  logic [31:0] lv_b   [12] = '{32'h00FF_00FF, 32'h00FF_00FF, 32'h0000_0001, 32'h0000_0001,
                               32'h0000_0007, 32'h00FF_00FF, 32'h00FF_00FF, 32'h0000_0001,
                               32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [31:0] lv_exp [12] = '{32'h000F_00F0, 32'h0FFF_F0FF, 32'h0000_0000, 32'h8000_0000,
                               32'hFFFF_FFFE, 32'hF000_0F00, 32'h0FF0_F00F, 32'h0000_0001,
                               32'h0000_0000, 32'h0000_0000, 32'h0000_0001, 32'h0000_0000};

  // Shift vectors: ctl, in1 (low 5 bits = amount), in2, expected, amount
  logic [4:0]  sv_ctl [7] = '{OP_SRA, OP_SLL, OP_SLL, OP_SRL, OP_SRA, OP_SRL, OP_SLL};
  logic [31:0] sv_a   [7] = '{32'd4, 32'd0, 32'd8, 32'd31, 32'd1, 32'hFFFF_FFE3, 32'd31};
  logic [31:0] sv_b   [7] = '{32'h8000_0000, 32'h1234_5678, 32'h0000_00FF, 32'h8000_0000,
                              32'h4000_0000, 32'h0000_00F0, 32'h0000_0003};
  logic [31:0] sv_exp [7] = '{32'hF800_0000, 32'h1234_5678, 32'h0000_FF00, 32'h0000_0001,
                              32'h2000_0000, 32'h0000_001E, 32'h8000_0000};
  int          sv_n   [7] = '{4, 0, 8, 31, 1, 3, 31};

  function automatic int shift_latency(input int n);
`ifdef ALU_FAST_SHIFT_EN
    return (n >= 0) ? 1 : 1;
`else
    return 1 + n;
`endif
  endfunction

  // Wait for in_ready, present one operation for exactly the accepting edge
  task automatic issue(input logic [4:0] ctl, input logic sg,
                       input logic [31:0] a, input logic [31:0] b);
    int guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 200) begin
      @(posedge clk); #1; guard++;
    end
    bus.alu_ctl  = ctl;
    bus.sign     = sg;
    bus.in1      = a;
    bus.in2      = b;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Edges after the accepting edge until out_valid; -1 if it never comes
  task automatic wait_valid(output int lat);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    if (bus.out_valid !== 1'b1) lat = -1;
  endtask

  task automatic take();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_checks++; if (bus.result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h want 00000000", bus.result); end
    n_checks++; if (bus.zero !== 1'b1) begin n_fail++; $display("FAIL reset_zero: got %b want 1", bus.zero); end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_cycle_ops();
    int lat;
    for (int i = 0; i < 12; i++) begin
      issue(lv_ctl[i], lv_sg[i], lv_a[i], lv_b[i]);
      wait_valid(lat);
      n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL op%0d_latency: got %0d want 1", i, lat); end
      n_checks++; if (bus.result !== lv_exp[i]) begin n_fail++; $display("FAIL op%0d_result: got %h want %h", i, bus.result, lv_exp[i]); end
      n_checks++; if (bus.zero !== (lv_exp[i] == 32'h0)) begin n_fail++; $display("FAIL op%0d_zero: got %b want %b", i, bus.zero, lv_exp[i] == 32'h0); end
      n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL op%0d_in_ready_busy: got %b want 0", i, bus.in_ready); end
      take();
    end
  endtask

  task automatic test_shift();
    int lat;
    for (int i = 0; i < 7; i++) begin
      issue(sv_ctl[i], 1'b0, sv_a[i], sv_b[i]);
      wait_valid(lat);
      n_checks++; if (lat !== shift_latency(sv_n[i])) begin n_fail++; $display("FAIL shift%0d_latency: got %0d want %0d", i, lat, shift_latency(sv_n[i])); end
      n_checks++; if (bus.result !== sv_exp[i]) begin n_fail++; $display("FAIL shift%0d_result: got %h want %h", i, bus.result, sv_exp[i]); end
      take();
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    issue(OP_XOR, 1'b0, 32'hA5A5_A5A5, 32'hFFFF_0000);
    wait_valid(lat);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL bp_latency: got %0d want 1", lat); end
    // Stray request while stalled must be ignored
    bus.alu_ctl = OP_AND; bus.in1 = 32'h0; bus.in2 = 32'h0; bus.in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid_c%0d: got %b want 1", c, bus.out_valid); end
      n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_c%0d: got %b want 0", c, bus.in_ready); end
      n_checks++; if (bus.result !== 32'h5A5A_A5A5) begin n_fail++; $display("FAIL bp_result_c%0d: got %h want 5a5aa5a5", c, bus.result); end
    end
    take();
    bus.in_valid = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_after_d_out_valid: got %b want 0", bus.out_valid); end
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_after_d_in_ready: got %b want 0", bus.in_ready); end
    n_checks++; if (bus.result !== 32'h5A5A_A5A5) begin n_fail++; $display("FAIL bp_after_d_result: got %h want 5a5aa5a5", bus.result); end
    @(posedge clk); #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_after_d1_in_ready: got %b want 1", bus.in_ready); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_after_d1_out_valid: got %b want 0", bus.out_valid); end
    issue(OP_SUB, 1'b0, 32'd10, 32'd3);
    wait_valid(lat);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL b2b_latency: got %0d want 1", lat); end
    n_checks++; if (bus.result !== 32'd7) begin n_fail++; $display("FAIL b2b_result: got %h want 00000007", bus.result); end
    take();
  endtask

  task automatic test_reset_mid_shift();
    int lat;
    issue(OP_SRL, 1'b0, 32'd20, 32'hFFFF_FFFF);
    repeat (6) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_out_valid: got %b want 0", bus.out_valid); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_in_ready: got %b want 1", bus.in_ready); end
    n_checks++; if (bus.result !== 32'h0) begin n_fail++; $display("FAIL rst_mid_result: got %h want 00000000", bus.result); end
    n_checks++; if (bus.zero !== 1'b1) begin n_fail++; $display("FAIL rst_mid_zero: got %b want 1", bus.zero); end
    @(posedge clk); #1;
    reset = 1'b1;
    issue(OP_AND, 1'b0, 32'h0000_F0F0, 32'h0000_FF00);
    wait_valid(lat);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL rst_next_latency: got %0d want 1", lat); end
    n_checks++; if (bus.result !== 32'h0000_F000) begin n_fail++; $display("FAIL rst_next_result: got %h want 0000f000", bus.result); end
    n_checks++; if (bus.zero !== 1'b0) begin n_fail++; $display("FAIL rst_next_zero: got %b want 0", bus.zero); end
    take();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.alu_ctl   = '0;
    bus.sign      = 1'b0;
    bus.in1       = '0;
    bus.in2       = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_single_cycle_ops();
    test_shift();
    test_back_to_back();
    test_reset_mid_shift();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks %0d failures %0d", n_checks, n_fail);
    $fatal(1);
  end

endmodule

// File: doc/alu_multicycle.md
# alu_multicycle

Iterative 32-bit execute unit that consumes the 5-bit ALU control code and `Sign` flag produced by the ALU control decoder and returns a result through a valid/ready handshake. Logic, add/sub and compare ops finish in one cycle. Shifts run one bit per cycle, which frees area for the multicycle datapath. It sits in the EX stage between the operand muxes and the EX/MEM register and stalls the pipeline through `in_ready` / `out_valid`.

## Interface
- `WIDTH`, 32, operand and result width. Shift count is always 5 bits.
- `clk` input 1 — rising-edge clock.
- `reset` input 1 — asynchronous, active-low reset.
- `in_valid` input 1 — the operation fields are valid.
- `in_ready` output 1 — the unit can accept an operation. High only in IDLE.
- `ALUCtl` input 5 — operation code: AND 00000, OR 00001, ADD 00010, SUB 00110, SLT 00111, NOR 01100, XOR 01101, SLL 10000, SRL 11000, SRA 11001.
- `Sign` input 1 — 1 selects a signed SLT compare, 0 selects unsigned.
- `in1` input WIDTH — operand A. For shifts, `in1[4:0]` is the shift amount.
- `in2` input WIDTH — operand B. For shifts, this is the data to shift.
- `out_valid` output 1 — `result` and `zero` are valid.
- `out_ready` input 1 — the consumer accepts the result.
- `result` output WIDTH — operation result.
- `zero` output 1 — equals `result == 0`.

## Operation
- FSM states are IDLE, SHIFT and DONE.
- Accept: a transfer happens on a rising edge when `in_valid && in_ready`. On accept, the unit latches ALUCtl, Sign, in2 and shamt.
- Non-shift op at accept: compute, register `result`, go to DONE.
- Shift op at accept:
  - If `shamt == 0`: `result = in2`, go to DONE.
  - Otherwise: load the working register with in2 and the counter with shamt, go to SHIFT.
- SHIFT, each cycle: shift the working register by one bit and decrement the counter.
  - SLL fills with 0.
  - SRL fills with 0.
  - SRA fills with the current bit 31.
  - When the counter decrements to 0, copy the working register to `result` and go to DONE.
- DONE: `out_valid = 1`, and `result` and `zero` hold steady. On `out_ready` go to IDLE. No bypass, so a new accept happens at the earliest one cycle after the output handshake.
- Arithmetic:
  - ADD and SUB wrap modulo 2^WIDTH. There is no overflow flag.
  - SLT returns 32'd1 or 32'd0. It compares signed when Sign=1 and unsigned when Sign=0.
  - NOR is `~(in1|in2)`.
- An undefined ALUCtl code yields `result = 0` in one cycle. It is never treated as an error.
- Inputs are ignored outside IDLE, so `in_valid` may toggle freely while busy.
- Reset is asynchronous and effective at any state, including mid-shift:
  - state goes to IDLE and the counter to 0.
  - `result` goes to 0, so `zero=1`.
  - `out_valid` goes to 0 and `in_ready` to 1.
  - A partial shift is discarded.

## Timing
- Let accept occur at edge E.
  - Non-shift op, or shift with shamt=0: `out_valid` is high after E+1.
  - Shift by n (1..31): `out_valid` is high after E+1+n.
- The output handshake at edge D takes the unit to IDLE. `in_ready` is high after D+1.
- `in_ready` and `out_valid` are never high together.
- All outputs come from registers. There is no combinational path from inputs to outputs.

## Configuration
- `ALU_FAST_SHIFT_EN`:
  - Defined: shifts use a single-cycle barrel shifter, so every op has 1-cycle latency and the SHIFT state and counter are compiled out.
  - Undefined: iterative shifting as specified above.
- Results are bit-identical in both builds. Only the latency differs.

## Test plan
- ADD: in1=32'hFFFF_FFFF, in2=1 -> `result=0`, `zero=1`, `out_valid` one cycle after accept.
- SLT with in1=32'h8000_0000, in2=1:
  - Sign=1 -> `result=1`.
  - Sign=0 -> `result=0`.
- SRA: in1=5'd4, in2=32'h8000_0000 -> `result=32'hF800_0000`, `out_valid` 5 cycles after accept.
  - With `ALU_FAST_SHIFT_EN`, `out_valid` is 1 cycle after accept.
- SLL with shamt=0, in2=32'h1234_5678 -> `result=32'h1234_5678` after 1 cycle.
- Back-pressure: hold `out_ready=0` for 3 cycles in DONE -> `result` is stable and `in_ready=0` throughout. A new `in_valid` presented during this time is ignored.
- Reset asserted during an SRL by 20 at cycle 7 -> immediately `out_valid=0`, `in_ready=1`, `result=0`. A next op (AND of 32'hF0F0 and 32'hFF00) gives 32'hF000.
